eeprom_read_manager: RTL and testbench
======================================

EEPROM_READ_MANAGER -- requirements
Module: eeprom_read_manager

Interface
REQ-001 Parameter CTRL_CODE, default 4'b1010, EEPROM device-type code sent as the first 4 bits of each control byte.
REQ-002 Parameter CHIP_SEL, default 3'b000, chip-select bits sent after CTRL_CODE and before the R/W bit.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 read_start  in  1  request to begin a read transaction; sampled only in IDLE.
REQ-006 rd_addr  in  16  EEPROM start address, high byte first on bus.
REQ-007 rd_len  in  8  number of bytes to read sequentially; 0 means no transaction.
REQ-008 com  out  2  bit-engine command: 2'b10 START, 2'b01 STOP, 2'b00 drive 0, 2'b11 drive/release 1.
REQ-009 en  out  1  bit-engine enable; held high with com stable until is_done seen.
REQ-010 is_done  in  1  bit engine reports command complete.
REQ-011 bit_in  in  1  SDA value sampled by the bit engine during the last 2'b11 command, valid while is_done=1.
REQ-012 data_out  out  8  last byte read, MSB first on bus.
REQ-013 data_valid  out  1  one-cycle pulse when data_out is updated.
REQ-014 busy  out  1  high from read_start acceptance until done pulse.
REQ-015 done  out  1  one-cycle pulse at transaction end (success or error).
REQ-016 error  out  1  sticky; set on slave NACK, cleared on next accepted read_start.

Function
REQ-017 In IDLE with read_start=1 and busy=0, the block shall latch rd_addr and rd_len, clear error, and set busy the next cycle.
REQ-018 read_start while busy=1 shall be ignored.
REQ-019 rd_len=0 on acceptance shall produce done one cycle later with no bus command, busy returning low, and error=0.
REQ-020 Handshake: per command, en=1 with com stable until is_done=1 is sampled; then en=0, and no new command until is_done=0 is sampled.
REQ-021 Command order: START; control byte {CTRL_CODE,CHIP_SEL,0}; ACK slot; addr high; ACK slot; addr low; ACK slot; START (repeated); {CTRL_CODE,CHIP_SEL,1}; ACK slot; then per byte: 8 read slots and a master ACK/NACK.
REQ-022 Bytes shall be sent MSB first, each bit as 2'b11 for 1 or 2'b00 for 0.
REQ-023 ACK slot: issue 2'b11; bit_in=0 at is_done means ACK and the sequence continues; bit_in=1 means NACK.
REQ-024 On slave NACK, the block shall issue STOP, then set error=1, pulse done, clear busy, and return to IDLE.
REQ-025 Read slot: issue 2'b11 and shift bit_in into the byte register MSB first.
REQ-026 After the 8th read slot, data_out shall update and data_valid pulse on the same cycle, before the master ACK slot.
REQ-027 Master ACK slot: 2'b00 if bytes remain, 2'b11 (NACK) after the last byte, then STOP.
REQ-028 done shall pulse, and busy fall, one cycle after is_done of the final STOP is sampled.
REQ-029 The bit counter shall be 4 bits and the byte counter 8 bits; rd_len=255 shall yield exactly 255 data_valid pulses; address wrap is left to the EEPROM.
REQ-030 Any unreachable state code shall force STOP, set error, and return to IDLE.

Reset
REQ-031 rst_n low shall immediately force IDLE, en=0, com=2'b01, data_out=0, data_valid=0, busy=0, done=0, error=0, and clear all counters.
REQ-032 Reset mid-transaction shall abort without issuing STOP; the first command after reset shall be START.

Verification
REQ-033 Bit-engine model ACKs all; rd_addr=16'h0123, rd_len=1, EEPROM byte 8'hA5 -> bits 10100000,00000001,00100011, repeated START, 10100001; data_out=8'hA5 with one data_valid; NACK; STOP; one done; error=0.
REQ-034 rd_len=3, bytes 8'h11,8'h22,8'h33 -> three data_valid pulses in order; master ACK,ACK,NACK; single STOP.
REQ-035 Model NACKs the address-high ACK slot -> STOP issued, no data_valid, done pulse, error=1 held until next read_start.
REQ-036 rd_len=0 -> no en assertion, done one cycle after busy rise, error=0.
REQ-037 read_start pulsed again mid-transaction with rd_len=5 -> ignored, original rd_len honoured.
REQ-038 rst_n low during the 4th read slot -> all outputs at reset values asynchronously; next read_start starts with START.

Source files
------------

// File: rtl/eeprom_read_if.sv
// Host request/status and bit-engine handshake signals for the EEPROM read manager.
// master: the read manager itself; slave: the host plus the bit engine facing it.
interface eeprom_read_if;
  logic        read_start;
  logic [15:0] rd_addr;
  logic [7:0]  rd_len;
  logic [1:0]  com;
  logic        en;
  logic        is_done;
  logic        bit_in;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  read_start, rd_addr, rd_len, is_done, bit_in,
    output com, en, data_out, data_valid, busy, done, error
  );

  modport slave (
    output read_start, rd_addr, rd_len, is_done, bit_in,
    input  com, en, data_out, data_valid, busy, done, error
  );
endinterface

// File: rtl/eeprom_read_manager.sv
// Sequential-read transaction sequencer for an I2C EEPROM. It drives a bit engine
// one command at a time (START, STOP, bit 0, bit 1/release) and collects read bytes.
module eeprom_read_manager #(
  parameter logic [3:0] CTRL_CODE = 4'b1010,
  parameter logic [2:0] CHIP_SEL  = 3'b000
) (
  input  logic          clk,
  input  logic          rst_n,
  eeprom_read_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ZERO, ST_START1, ST_WBYTE, ST_WACK,
    ST_START2, ST_RBIT, ST_MACK, ST_STOP
  } state_t;

  // Each command goes ARM (wait for engine idle) -> CMD (en high) -> REL (wait is_done low).
  typedef enum logic [1:0] {PH_ARM, PH_CMD, PH_REL} phase_t;

  state_t      state, state_nx;
  phase_t      phase, phase_nx;
  logic [15:0] addr_q;
  logic [7:0]  byte_cnt;
  logic [3:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  shreg;
  logic        samp_q;
  logic        nack_q;
  logic [7:0]  tx_byte;
  logic [7:0]  tx_shift;
  logic        fire, adv;
  logic        accept, capture, shift, bit_clr, bit_inc, idx_inc;
  logic        dec_byte, load_data, set_nack, finish;

  assign fire = (phase == PH_CMD) && bus.is_done;
  assign adv  = (phase == PH_REL) && !bus.is_done;

  // Byte being written: write control, address high, address low, read control.
  always_comb begin
    tx_byte = {CTRL_CODE, CHIP_SEL, 1'b0};
    case (byte_idx)
      2'd1:    tx_byte = addr_q[15:8];
      2'd2:    tx_byte = addr_q[7:0];
      2'd3:    tx_byte = {CTRL_CODE, CHIP_SEL, 1'b1};
      default: tx_byte = {CTRL_CODE, CHIP_SEL, 1'b0};
    endcase
  end

  // MSB-first bit selection without indexing by the 4-bit counter.
  assign tx_shift = tx_byte << bit_cnt;

  // State and handshake-phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= PH_CMD;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    accept    = 1'b0;
    capture   = 1'b0;
    shift     = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    idx_inc   = 1'b0;
    dec_byte  = 1'b0;
    load_data = 1'b0;
    set_nack  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.read_start) begin
          accept   = 1'b1;
          phase_nx = PH_ARM;
          state_nx = (bus.rd_len == 8'd0) ? ST_ZERO : ST_START1;
        end
      end
      ST_ZERO: begin
        finish   = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_START1, ST_WBYTE, ST_WACK, ST_START2, ST_RBIT, ST_MACK, ST_STOP: begin
        if ((phase == PH_ARM) && !bus.is_done) phase_nx = PH_CMD;
        if (fire) begin
          phase_nx = PH_REL;
          capture  = 1'b1;
        end
        if (adv) phase_nx = PH_CMD;
        case (state)
          ST_START1, ST_START2: if (adv) state_nx = ST_WBYTE;
          ST_WBYTE: begin
            if (adv) begin
              if (bit_cnt == 4'd7) begin
                bit_clr  = 1'b1;
                state_nx = ST_WACK;
              end else begin
                bit_inc = 1'b1;
              end
            end
          end
          ST_WACK: begin
            if (adv) begin
              if (samp_q) begin
                set_nack = 1'b1;
                state_nx = ST_STOP;
              end else if (byte_idx == 2'd2) begin
                idx_inc  = 1'b1;
                state_nx = ST_START2;
              end else if (byte_idx == 2'd3) begin
                state_nx = ST_RBIT;
              end else begin
                idx_inc  = 1'b1;
                state_nx = ST_WBYTE;
              end
            end
          end
          ST_RBIT: begin
            shift = fire;
            if (adv) begin
              if (bit_cnt == 4'd7) begin
                bit_clr   = 1'b1;
                load_data = 1'b1;
                state_nx  = ST_MACK;
              end else begin
                bit_inc = 1'b1;
              end
            end
          end
          ST_MACK: begin
            if (adv) begin
              if (byte_cnt == 8'd1) begin
                state_nx = ST_STOP;
              end else begin
                dec_byte = 1'b1;
                state_nx = ST_RBIT;
              end
            end
          end
          ST_STOP: begin
            if (fire) begin
              finish   = 1'b1;
              phase_nx = PH_CMD;
              state_nx = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
      default: begin
        set_nack = 1'b1;
        phase_nx = PH_ARM;
        state_nx = ST_STOP;
      end
    endcase
  end

  // Bit-engine command outputs; idle level is STOP with enable low.
  always_comb begin
    bus.en  = 1'b0;
    bus.com = 2'b01;
    case (state)
      ST_START1, ST_START2: bus.com = 2'b10;
      ST_WBYTE:             bus.com = {tx_shift[7], tx_shift[7]};
      ST_WACK, ST_RBIT:     bus.com = 2'b11;
      ST_MACK:              bus.com = (byte_cnt == 8'd1) ? 2'b11 : 2'b00;
      default:              bus.com = 2'b01;
    endcase
    if ((state != ST_IDLE) && (state != ST_ZERO) && (phase == PH_CMD)) bus.en = 1'b1;
  end

  // Transaction registers, counters and host-visible status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      byte_cnt       <= '0;
      bit_cnt        <= '0;
      byte_idx       <= '0;
      shreg          <= '0;
      samp_q         <= 1'b0;
      nack_q         <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.data_valid <= load_data;
      bus.done       <= finish;
      if (accept) begin
        addr_q    <= bus.rd_addr;
        byte_cnt  <= bus.rd_len;
        bit_cnt   <= '0;
        byte_idx  <= '0;
        nack_q    <= 1'b0;
        bus.error <= 1'b0;
        bus.busy  <= 1'b1;
      end
      if (capture) samp_q <= bus.bit_in;
      if (shift) shreg <= {shreg[6:0], bus.bit_in};
      if (bit_clr) bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
      if (idx_inc) byte_idx <= byte_idx + 2'd1;
      if (dec_byte) byte_cnt <= byte_cnt - 8'd1;
      if (load_data) bus.data_out <= shreg;
      if (set_nack) nack_q <= 1'b1;
      if (finish) begin
        bus.busy  <= 1'b0;
        bus.error <= nack_q;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_read_manager.sv
// Bench for eeprom_read_manager: a bit-engine/EEPROM model plus scoreboard queues.
module tb_eeprom_read_manager;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eeprom_read_if ifc();

  eeprom_read_manager #(.CTRL_CODE(4'b1010), .CHIP_SEL(3'b000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.master)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [1:0] exp_cmd[$];
  logic [7:0] exp_data[$];
  logic       exp_err[$];

  logic [7:0] ee_mem[8];
  int         nack_pos = -1;
  logic       seen, in_tx, rep;
  int         pos;
  int         cmd_idx = 0;
  logic [1:0] cmd_com;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_cmd.push_back(b[i] ? 2'b11 : 2'b00);
  endtask

  // START, write control, address, repeated START, read control, each with its ACK slot.
  task automatic push_header(input logic [15:0] a);
    exp_cmd.push_back(2'b10);
    push_byte(8'hA0); exp_cmd.push_back(2'b11);
    push_byte(a[15:8]); exp_cmd.push_back(2'b11);
    push_byte(a[7:0]); exp_cmd.push_back(2'b11);
    exp_cmd.push_back(2'b10);
    push_byte(8'hA1); exp_cmd.push_back(2'b11);
  endtask

  task automatic push_reads(input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) exp_cmd.push_back(2'b11);
      exp_cmd.push_back((b == n - 1) ? 2'b11 : 2'b00);
    end
  endtask

  task automatic start_read(input logic [15:0] a, input logic [7:0] len);
    @(posedge clk); #1;
    ifc.read_start = 1'b1;
    ifc.rd_addr    = a;
    ifc.rd_len     = len;
    @(posedge clk); #1;
    ifc.read_start = 1'b0;
    check("busy_after_accept", ifc.busy, 1'b1);
    check("error_cleared", ifc.error, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!ifc.done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, ifc.done, 1'b1);
    check({name, "_busy"}, ifc.busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_queues_empty"}, exp_cmd.size() + exp_data.size() + exp_err.size(), 0);
  endtask

  // Bit engine + EEPROM model; also the command monitor.
  initial begin
    ifc.is_done = 1'b0; ifc.bit_in = 1'b0;
    seen = 1'b0; in_tx = 1'b0; rep = 1'b0; pos = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ifc.is_done = 1'b0; ifc.bit_in = 1'b0;
        seen = 1'b0; in_tx = 1'b0; rep = 1'b0; pos = 0;
      end else if (ifc.is_done) begin
        if (!ifc.en) ifc.is_done = 1'b0;
      end else if (ifc.en) begin
        if (!seen) begin
          seen = 1'b1;
          cmd_com = ifc.com;
        end else begin
          check("com_stable", ifc.com, cmd_com);
          if (exp_cmd.size() == 0) unexpected($sformatf("cmd%0d", cmd_idx), ifc.com);
          else check($sformatf("cmd%0d", cmd_idx), ifc.com, exp_cmd.pop_front());
          cmd_idx++;
          if (ifc.com == 2'b10) begin
            if (in_tx) rep = 1'b1;
            else begin in_tx = 1'b1; rep = 1'b0; end
            pos = 0;
          end else if (ifc.com == 2'b01) begin
            in_tx = 1'b0; rep = 1'b0; pos = 0;
          end else begin
            if (!rep) ifc.bit_in = (pos == nack_pos);
            else if (pos < 9) ifc.bit_in = 1'b0;
            else if ((pos - 9) % 9 < 8) ifc.bit_in = ee_mem[(pos - 9) / 9][7 - ((pos - 9) % 9)];
            else ifc.bit_in = 1'b1;
            pos++;
          end
          ifc.is_done = 1'b1;
          seen = 1'b0;
        end
      end
    end
  end

  // Output monitor: data bytes and end-of-transaction status.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (ifc.data_valid) begin
          if (exp_data.size() == 0) unexpected("data_valid", ifc.data_out);
          else check("data_out", ifc.data_out, exp_data.pop_front());
        end
        if (ifc.done) begin
          if (exp_err.size() == 0) unexpected("done", ifc.error);
          else check("error_at_done", ifc.error, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ifc.read_start = 1'b0; ifc.rd_addr = '0; ifc.rd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", ifc.en, 1'b0);
    check("rst_com", ifc.com, 2'b01);
    check("rst_data_out", ifc.data_out, 8'h00);
    check("rst_data_valid", ifc.data_valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_done", ifc.done, 1'b0);
    check("rst_error", ifc.error, 1'b0);
    rst_n = 1'b1;

    // Single byte read from 0x0123.
    ee_mem[0] = 8'hA5;
    push_header(16'h0123); push_reads(1); exp_cmd.push_back(2'b01);
    exp_data.push_back(8'hA5); exp_err.push_back(1'b0);
    start_read(16'h0123, 8'd1);
    wait_done("t1_done");

    // Three byte read: master ACK, ACK, NACK then one STOP.
    ee_mem[0] = 8'h11; ee_mem[1] = 8'h22; ee_mem[2] = 8'h33;
    push_header(16'h4567); push_reads(3); exp_cmd.push_back(2'b01);
    exp_data.push_back(8'h11); exp_data.push_back(8'h22); exp_data.push_back(8'h33);
    exp_err.push_back(1'b0);
    start_read(16'h4567, 8'd3);
    wait_done("t2_done");

    // Slave NACKs the address-high byte.
    nack_pos = 17;
    exp_cmd.push_back(2'b10);
    push_byte(8'hA0); exp_cmd.push_back(2'b11);
    push_byte(8'h01); exp_cmd.push_back(2'b11);
    exp_cmd.push_back(2'b01);
    exp_err.push_back(1'b1);
    start_read(16'h0123, 8'd2);
    wait_done("t3_done");
    repeat (5) @(posedge clk);
    #1;
    check("t3_error_sticky", ifc.error, 1'b1);
    nack_pos = -1;

    // Zero-length request: no bus activity, done right after busy.
    exp_err.push_back(1'b0);
    @(posedge clk); #1;
    ifc.read_start = 1'b1; ifc.rd_len = 8'd0; ifc.rd_addr = 16'h0055;
    @(posedge clk); #1;
    ifc.read_start = 1'b0;
    check("t4_busy", ifc.busy, 1'b1);
    check("t4_done_low", ifc.done, 1'b0);
    check("t4_error_cleared", ifc.error, 1'b0);
    check("t4_en", ifc.en, 1'b0);
    @(posedge clk); #1;
    check("t4_done", ifc.done, 1'b1);
    check("t4_busy_low", ifc.busy, 1'b0);
    check("t4_en2", ifc.en, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_queues_empty", exp_cmd.size() + exp_data.size() + exp_err.size(), 0);

    // Five byte read with a second request while busy.
    ee_mem[0] = 8'h3C; ee_mem[1] = 8'hC3; ee_mem[2] = 8'h5A; ee_mem[3] = 8'h0F; ee_mem[4] = 8'hF0;
    push_header(16'h0010); push_reads(5); exp_cmd.push_back(2'b01);
    exp_data.push_back(8'h3C); exp_data.push_back(8'hC3); exp_data.push_back(8'h5A);
    exp_data.push_back(8'h0F); exp_data.push_back(8'hF0);
    exp_err.push_back(1'b0);
    start_read(16'h0010, 8'd5);
    repeat (20) @(posedge clk);
    #1;
    ifc.read_start = 1'b1; ifc.rd_len = 8'd2; ifc.rd_addr = 16'hFFFF;
    @(posedge clk); #1;
    ifc.read_start = 1'b0;
    check("t5_still_busy", ifc.busy, 1'b1);
    wait_done("t5_done");

    // Reset during the fourth read slot.
    ee_mem[0] = 8'h77; ee_mem[1] = 8'h88;
    push_header(16'h0200);
    for (int i = 0; i < 3; i++) exp_cmd.push_back(2'b11);
    start_read(16'h0200, 8'd2);
    begin
      int k = 0;
      while (!(ifc.en && rep && pos == 12 && !ifc.is_done) && k < 3000) begin
        @(posedge clk); #2;
        k++;
      end
      check("t6_reached_slot4", ifc.en, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", ifc.en, 1'b0);
    check("t6_rst_com", ifc.com, 2'b01);
    check("t6_rst_data_out", ifc.data_out, 8'h00);
    check("t6_rst_busy", ifc.busy, 1'b0);
    check("t6_rst_done", ifc.done, 1'b0);
    check("t6_rst_error", ifc.error, 1'b0);
    check("t6_cmds_consumed", exp_cmd.size(), 0);
    exp_cmd.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh transaction after reset must begin with START.
    ee_mem[0] = 8'h96;
    push_header(16'h0123); push_reads(1); exp_cmd.push_back(2'b01);
    exp_data.push_back(8'h96); exp_err.push_back(1'b0);
    start_read(16'h0123, 8'd1);
    wait_done("t7_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
